logic_op_arbiter: RTL and testbench
===================================

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-low, and the ports are named clk_in and rst_n_in.
REQ-002 clk_in  input  1  block clock; all state updates on rising edge.
REQ-003 rst_n_in  input  1  synchronous active-low reset.
REQ-004 req0_valid_in / req1_valid_in  input  1 each  requester 0/1 has an operation pending.
REQ-005 req0_ready_out / req1_ready_out  output  1 each  requester 0/1 operation accepted this cycle.
REQ-006 req0_op_in / req1_op_in  input  3 each  opcode.
REQ-007 req0_a_in, req0_b_in, req1_a_in, req1_b_in  input  8 each  operands.
REQ-008 res_valid_out  output  1  result available.
REQ-009 res_ready_in  input  1  consumer takes result.
REQ-010 res_data_out  output  8  result byte.
REQ-011 res_id_out  output  1  requester that issued the result.
REQ-012 done_cnt_out  output  8  count of completed results, wraps.

Function
REQ-013 The opcode map SHALL be: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NOT a, 5 NAND, 6 NOR, 7 PASS a; all operations are bitwise over 8 bits, and b is ignored for opcodes 4 and 7.
REQ-014 The FSM SHALL have the states IDLE, EXEC and DONE: IDLE->EXEC on an accepted request, EXEC->DONE unconditionally, DONE->IDLE when res_valid_out && res_ready_in.
REQ-015 In IDLE, the block SHALL assert reqN_ready_out for exactly one requester with valid high (the grant), and never for both; ready SHALL be 0 in EXEC and DONE.
REQ-016 Arbitration SHALL be round-robin:
- pointer rr_ptr names the preferred requester;
- if only one requester is valid, that requester wins;
- if both are valid, requester rr_ptr wins;
- after every grant, rr_ptr becomes the non-granted index.
REQ-017 On acceptance, the block SHALL latch the opcode, both operands and the requester id.
REQ-018 In EXEC, the block SHALL compute the result from the latched values and register it.
REQ-019 res_valid_out SHALL rise 2 cycles after the accept edge.
REQ-020 In DONE, res_valid_out SHALL be 1, and res_data_out and res_id_out SHALL stay stable until the handshake completes.
REQ-021 A new request SHALL be accepted no earlier than the cycle after the DONE->IDLE transition, giving a minimum 3-cycle issue interval.
REQ-022 Requester inputs that change while the block is not in IDLE SHALL have no effect.
REQ-023 done_cnt_out SHALL increment by 1 on each result handshake and wrap from 255 to 0.

Reset
REQ-024 When rst_n_in=0 at a clock edge, in any state (mid-operation included), the block SHALL:
- go to IDLE;
- set rr_ptr=0 and done_cnt_out=0;
- set res_valid_out=0, res_data_out=0, res_id_out=0 and both ready outputs to 0;
- discard any latched operation.
REQ-025 On the first cycle after reset release, the block SHALL be able to accept a request.

Configuration
REQ-026 With macro LOGIC_ARB_ZERO_FLAG_EN defined, the block SHALL add output res_zero_out (1 bit): it is registered with the result, is 1 when the result equals 8'h00, holds with the result and resets to 0.
REQ-027 Without LOGIC_ARB_ZERO_FLAG_EN, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package logic_arb_pkg SHALL hold:
- the opcode enum;
- the FSM state enum;
- the data-width constant (8).
REQ-029 The combinational operation decode SHALL be a sub-module, logic_op_unit (inputs op, a, b; output y), instantiated once.

Verification
REQ-030 Single op: req0 {op=0, a=8'hF0, b=8'h3C} -> accept edge N, res_valid_out at N+2, res_data_out=8'h30, res_id_out=0.
REQ-031 All opcodes with a=8'hA5, b=8'h0F -> results 05, AF, AA, 55, 5A, FA, 50, A5 in opcode order.
REQ-032 Contention: both requesters valid continuously after reset -> grants alternate 0,1,0,1, and done_cnt_out=4 after four handshakes.
REQ-033 Backpressure: hold res_ready_in=0 for 5 cycles in DONE -> data/id stable, no ready asserted, done_cnt_out unchanged.
REQ-034 Mid-op reset: assert rst_n_in low during EXEC -> next cycle IDLE, res_valid_out=0, done_cnt_out=0, rr_ptr=0.
REQ-035 Wrap and flag: run 256 handshakes -> done_cnt_out=0; with LOGIC_ARB_ZERO_FLAG_EN, op=0, a=8'h0F, b=8'hF0 -> res_zero_out=1.

Source files
------------

// File: rtl/logic_arb_pkg.sv
// logic_arb_pkg: opcode and FSM state types plus datapath width for logic_op_arbiter
package logic_arb_pkg;
    localparam int DW = 8;
    typedef enum logic [2:0] {
        OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NOTA, OP_NAND, OP_NOR, OP_PASSA
    } op_e;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
endpackage

// File: rtl/logic_op_unit.sv
// logic_op_unit: combinational bitwise operation decode (b ignored for NOT a and PASS a)
module logic_op_unit
    import logic_arb_pkg::*;
(
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);
    // decode the opcode into its bitwise function
    always_comb begin
        case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            default: y = a;
        endcase
    end
endmodule

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin two-requester bitwise op unit; LOGIC_ARB_ZERO_FLAG_EN adds res_zero_out
module logic_op_arbiter
    import logic_arb_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          req0_valid_in,
    input  logic          req1_valid_in,
    output logic          req0_ready_out,
    output logic          req1_ready_out,
    input  logic [2:0]    req0_op_in,
    input  logic [2:0]    req1_op_in,
    input  logic [DW-1:0] req0_a_in,
    input  logic [DW-1:0] req0_b_in,
    input  logic [DW-1:0] req1_a_in,
    input  logic [DW-1:0] req1_b_in,
    output logic          res_valid_out,
    input  logic          res_ready_in,
    output logic [DW-1:0] res_data_out,
    output logic          res_id_out,
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    output logic          res_zero_out,
`endif
    output logic [7:0]    done_cnt_out
);
    state_e        state, state_nxt;
    logic          rr_ptr;
    logic          accept;
    logic          hs;
    logic [2:0]    op_q;
    logic [DW-1:0] a_q, b_q, y;
    logic          id_q;

    logic_op_unit u_op (.op(op_q), .a(a_q), .b(b_q), .y(y));

    assign accept        = req0_ready_out || req1_ready_out;
    assign res_valid_out = (state == DONE);
    assign hs            = res_valid_out && res_ready_in;

    // next state and grant: only IDLE grants, the preferred requester wins a tie
    always_comb begin
        state_nxt      = state;
        req0_ready_out = 1'b0;
        req1_ready_out = 1'b0;
        case (state)
            IDLE: begin
                req0_ready_out = rst_n_in && req0_valid_in && (!req1_valid_in || !rr_ptr);
                req1_ready_out = rst_n_in && req1_valid_in && (!req0_valid_in || rr_ptr);
                state_nxt      = (req0_valid_in || req1_valid_in) ? EXEC : IDLE;
            end
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = res_ready_in ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    // latch the granted operation, register its result, count handshakes
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rr_ptr       <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            res_data_out <= '0;
            res_id_out   <= 1'b0;
            done_cnt_out <= '0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            res_zero_out <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q   <= req1_ready_out ? req1_op_in : req0_op_in;
                a_q    <= req1_ready_out ? req1_a_in  : req0_a_in;
                b_q    <= req1_ready_out ? req1_b_in  : req0_b_in;
                id_q   <= req1_ready_out;
                rr_ptr <= req0_ready_out;
            end
            if (state == EXEC) begin
                res_data_out <= y;
                res_id_out   <= id_q;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
                res_zero_out <= (y == '0);
`endif
            end
            if (hs) done_cnt_out <= done_cnt_out + 8'd1;
        end
    end
endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: directed and randomized checks of logic_op_arbiter against a transaction-level model
module tb_logic_op_arbiter;
    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       req0_valid_in, req1_valid_in;
    logic       req0_ready_out, req1_ready_out;
    logic [2:0] req0_op_in, req1_op_in;
    logic [7:0] req0_a_in, req0_b_in, req1_a_in, req1_b_in;
    logic       res_valid_out, res_ready_in;
    logic [7:0] res_data_out;
    logic       res_id_out;
    logic [7:0] done_cnt_out;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic       res_zero_out;
`endif

    int checks = 0;
    int passes = 0;

    logic_op_arbiter dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req0_valid_in(req0_valid_in), .req1_valid_in(req1_valid_in),
        .req0_ready_out(req0_ready_out), .req1_ready_out(req1_ready_out),
        .req0_op_in(req0_op_in), .req1_op_in(req1_op_in),
        .req0_a_in(req0_a_in), .req0_b_in(req0_b_in),
        .req1_a_in(req1_a_in), .req1_b_in(req1_b_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
        .res_data_out(res_data_out), .res_id_out(res_id_out),
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        .res_zero_out(res_zero_out),
`endif
        .done_cnt_out(done_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r [8];
        r[0] = a & b; r[1] = a | b; r[2] = a ^ b; r[3] = ~(a ^ b);
        r[4] = ~a;    r[5] = ~(a & b); r[6] = ~(a | b); r[7] = a;
        return r[op];
    endfunction

    // transaction-level model: a job is free, computing, or holding its result
    bit         m_known = 0;
    int         m_phase;
    bit         m_pref;
    logic [7:0] m_pend, m_data, m_cnt;
    bit         m_pend_id, m_id, m_zero;

    always @(negedge clk_in) begin
        bit e0, e1, win;
        if (m_known) begin
            e0 = rst_n_in && m_phase == 0 && req0_valid_in && (!req1_valid_in || !m_pref);
            e1 = rst_n_in && m_phase == 0 && req1_valid_in && (!req0_valid_in || m_pref);
            check("ready0", {7'd0, req0_ready_out}, {7'd0, e0});
            check("ready1", {7'd0, req1_ready_out}, {7'd0, e1});
            check("res_valid", {7'd0, res_valid_out}, {7'd0, m_phase == 2});
            check("res_data", res_data_out, m_data);
            check("res_id", {7'd0, res_id_out}, {7'd0, m_id});
            check("done_cnt", done_cnt_out, m_cnt);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            check("res_zero", {7'd0, res_zero_out}, {7'd0, m_zero});
`endif
        end
        if (!rst_n_in) begin
            m_known = 1; m_phase = 0; m_pref = 0; m_pend = 0; m_pend_id = 0;
            m_data = 0; m_id = 0; m_cnt = 0; m_zero = 0;
        end else if (m_known) begin
            if (m_phase == 0 && (req0_valid_in || req1_valid_in)) begin
                win       = (req0_valid_in && req1_valid_in) ? m_pref : req1_valid_in;
                m_pend    = win ? ref_op(req1_op_in, req1_a_in, req1_b_in) : ref_op(req0_op_in, req0_a_in, req0_b_in);
                m_pend_id = win;
                m_pref    = !win;
                m_phase   = 1;
            end else if (m_phase == 1) begin
                m_data  = m_pend;
                m_id    = m_pend_id;
                m_zero  = (m_pend == 0);
                m_phase = 2;
            end else if (m_phase == 2 && res_ready_in) begin
                m_cnt   = m_cnt + 8'd1;
                m_phase = 0;
            end
        end
    end

    initial begin
        logic [7:0] exp_tab [8];
        int t, hs;
        exp_tab = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'h5A, 8'hFA, 8'h50, 8'hA5};
        rst_n_in = 0; res_ready_in = 0;
        req0_valid_in = 1; req1_valid_in = 0;
        req0_op_in = 0; req1_op_in = 0;
        req0_a_in = 0; req0_b_in = 0; req1_a_in = 0; req1_b_in = 0;
        tick(); tick();
        check("rst_ready0", {7'd0, req0_ready_out}, 8'd0);
        check("rst_valid", {7'd0, res_valid_out}, 8'd0);
        check("rst_cnt", done_cnt_out, 8'd0);
        check("rst_data", res_data_out, 8'd0);

        // single AND op from requester 0
        rst_n_in = 1; req0_op_in = 0; req0_a_in = 8'hF0; req0_b_in = 8'h3C;
        #1 check("first_ready0", {7'd0, req0_ready_out}, 8'd1);
        tick(); req0_valid_in = 0;
        check("exec_valid", {7'd0, res_valid_out}, 8'd0);
        tick();
        check("single_valid", {7'd0, res_valid_out}, 8'd1);
        check("single_data", res_data_out, 8'h30);
        check("single_id", {7'd0, res_id_out}, 8'd0);
        res_ready_in = 1;
        tick();
        check("single_cnt", done_cnt_out, 8'd1);

        // every opcode from requester 1
        for (int op = 0; op < 8; op++) begin
            req1_valid_in = 1; req1_op_in = 3'(op); req1_a_in = 8'hA5; req1_b_in = 8'h0F;
            tick(); req1_valid_in = 0;
            tick();
            check("opcode_data", res_data_out, exp_tab[op]);
            check("opcode_id", {7'd0, res_id_out}, 8'd1);
            tick();
        end
        check("opcode_cnt", done_cnt_out, 8'd9);

        // backpressure with both requesters churning
        res_ready_in = 0; req0_valid_in = 1; req0_op_in = 1; req0_a_in = 8'h12; req0_b_in = 8'h40;
        tick(); req1_valid_in = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {7'd0, res_valid_out}, 8'd1);
            check("bp_data", res_data_out, 8'h52);
            check("bp_id", {7'd0, res_id_out}, 8'd0);
            check("bp_ready", {6'd0, req1_ready_out, req0_ready_out}, 8'd0);
            check("bp_cnt", done_cnt_out, 8'd9);
            req0_op_in = 3'($urandom); req0_a_in = 8'($urandom); req1_a_in = 8'($urandom);
            tick();
        end
        res_ready_in = 1;
        tick(); req0_valid_in = 0; req1_valid_in = 0;
        check("bp_cnt_after", done_cnt_out, 8'd10);

        // reset during EXEC after a requester-0 grant
        req0_valid_in = 1;
        tick(); req0_valid_in = 0; rst_n_in = 0;
        tick(); rst_n_in = 1;
        check("mid_valid", {7'd0, res_valid_out}, 8'd0);
        check("mid_cnt", done_cnt_out, 8'd0);
        check("mid_data", res_data_out, 8'd0);
        req0_valid_in = 1; req1_valid_in = 1;
        #1 check("mid_ptr", {6'd0, req1_ready_out, req0_ready_out}, 8'd1);

        // contention: grants alternate
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!(req0_ready_out || req1_ready_out) && t < 10) begin tick(); t++; end
            check("grant_timeout", {7'd0, t < 10}, 8'd1);
            check("grant_order", {7'd0, req1_ready_out}, 8'(k % 2));
            tick();
        end
        tick(); tick();
        check("contend_cnt", done_cnt_out, 8'd4);
        req0_valid_in = 0; req1_valid_in = 0;
        tick();

        // 256 handshakes wrap the counter; AND of 0F/F0 is zero
        rst_n_in = 0; tick(); rst_n_in = 1;
        req0_valid_in = 1; req0_op_in = 0; req0_a_in = 8'h0F; req0_b_in = 8'hF0;
        hs = 0; t = 0;
        while (hs < 256 && t < 1000) begin
            if (res_valid_out) hs++;
            tick(); t++;
        end
        req0_valid_in = 0;
        check("wrap_timeout", {7'd0, t < 1000}, 8'd1);
        check("wrap_cnt", done_cnt_out, 8'd0);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        check("zero_flag", {7'd0, res_zero_out}, 8'd1);
`endif

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n_in      = ($urandom_range(63) != 0);
            req0_valid_in = 1'($urandom); req1_valid_in = 1'($urandom);
            res_ready_in  = ($urandom_range(3) != 0);
            req0_op_in = 3'($urandom); req1_op_in = 3'($urandom);
            req0_a_in = 8'($urandom); req0_b_in = 8'($urandom);
            req1_a_in = 8'($urandom); req1_b_in = 8'($urandom);
            tick();
        end
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
